// File: rtl/reorder_buffer_pkg.sv
// Shared defaults and tag arithmetic for the reorder buffer.
// Tag 0 means "no tag", so the increment skips it on wrap.
package rob_defs;

  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int Q_WIDTH_DEF        = 4;

  // Advance a tag in 1..2**qw-1, wrapping back to 1.
  function automatic logic [31:0] tag_inc(input logic [31:0] tag, input int unsigned qw);
    logic [31:0] nxt;
    nxt = tag + 32'd1;
    if (nxt >= (32'd1 << qw)) return 32'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/reorder_buffer_fwd.sv
// Operand lookup for one read port: entry state with same-cycle
// writeback forwarding (ex over slb over stored value).
module rob_fwd #(
  parameter int Q_WIDTH = 4
) (
  input  logic [Q_WIDTH-1:0] i_tag,
  input  logic               i_ex_valid,
  input  logic [Q_WIDTH-1:0] i_ex_tag,
  input  logic [31:0]        i_ex_value,
  input  logic               i_slb_valid,
  input  logic [Q_WIDTH-1:0] i_slb_tag,
  input  logic [31:0]        i_slb_value,
  input  logic               i_ent_ready,
  input  logic [31:0]        i_ent_value,
  output logic               o_ready,
  output logic [31:0]        o_value
);

  logic w_ex_hit, w_slb_hit;

  assign w_ex_hit  = i_ex_valid  && (i_ex_tag  == i_tag);
  assign w_slb_hit = i_slb_valid && (i_slb_tag == i_tag);

  always_comb begin
    o_ready = 1'b0;
    o_value = '0;
    if (i_tag != '0) begin
      o_ready = i_ent_ready | w_ex_hit | w_slb_hit;
      o_value = w_ex_hit ? i_ex_value : (w_slb_hit ? i_slb_value : i_ent_value);
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order issue, out-of-order writeback,
// up to two in-order commits per cycle, flush on branch mispredict.
module reorder_buffer
  import rob_defs::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int Q_WIDTH        = Q_WIDTH_DEF
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        issue_valid,
  input  logic                        issue_is_store,
  input  logic                        issue_is_branch,
  input  logic [REG_ADDR_WIDTH-1:0]   issue_rd,
  input  logic [31:0]                 issue_pred_pc,
  output logic [Q_WIDTH-1:0]          issue_tag,
  output logic                        full,
  output logic                        empty,
  input  logic                        ex_valid,
  input  logic [Q_WIDTH-1:0]          ex_tag,
  input  logic [31:0]                 ex_value,
  input  logic [31:0]                 ex_npc,
  input  logic                        slb_valid,
  input  logic [Q_WIDTH-1:0]          slb_tag,
  input  logic [31:0]                 slb_value,
  input  logic [Q_WIDTH-1:0]          rd_tag1,
  input  logic [Q_WIDTH-1:0]          rd_tag2,
  output logic                        rd_ready1,
  output logic                        rd_ready2,
  output logic [31:0]                 rd_value1,
  output logic [31:0]                 rd_value2,
  output logic [1:0]                  commit_valid,
  output logic [1:0]                  commit_wen,
  output logic [2*REG_ADDR_WIDTH-1:0] commit_rd,
  output logic [2*Q_WIDTH-1:0]        commit_tag,
  output logic [63:0]                 commit_value,
  output logic                        flush,
  output logic [31:0]                 flush_pc
);

  localparam int DEPTH = 1 << Q_WIDTH;
  typedef logic [Q_WIDTH-1:0] tag_t;

  tag_t r_head, r_tail, r_count;
  logic [DEPTH-1:0]                     r_ready, r_store, r_branch;
  logic [DEPTH-1:0][31:0]               r_value, r_npc, r_pred_pc;
  logic [DEPTH-1:0][REG_ADDR_WIDTH-1:0] r_rd;

  tag_t w_head1, w_head2, w_tail1, w_head_nxt, w_ncommit;
  logic w_empty, w_full, w_c0, w_c1, w_flush, w_issue;

  function automatic tag_t inc(input tag_t t);
    return tag_t'(tag_inc({{(32-Q_WIDTH){1'b0}}, t}, Q_WIDTH));
  endfunction

  assign w_head1 = inc(r_head);
  assign w_head2 = inc(w_head1);
  assign w_tail1 = inc(r_tail);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == tag_t'(DEPTH - 1));

  assign w_c0    = rdy_in && !w_empty && r_ready[r_head];
  assign w_flush = w_c0 && r_branch[r_head] && (r_npc[r_head] != r_pred_pc[r_head]);
  // Branches commit alone so a mispredict never drags a wrong-path entry along.
  assign w_c1    = w_c0 && (r_count >= tag_t'(2)) && r_ready[w_head1]
                && !r_branch[r_head] && !r_branch[w_head1];
  assign w_issue = issue_valid && !w_full && !w_flush && rdy_in;

  assign w_ncommit  = tag_t'(w_c0) + tag_t'(w_c1);
  assign w_head_nxt = w_c1 ? w_head2 : (w_c0 ? w_head1 : r_head);

  assign issue_tag    = r_tail;
  assign full         = w_full;
  assign empty        = w_empty;
  assign commit_valid = {w_c1, w_c0};
  assign commit_wen   = {w_c1 && !r_store[w_head1] && !r_branch[w_head1] && (r_rd[w_head1] != '0),
                         w_c0 && !r_store[r_head]  && !r_branch[r_head]  && (r_rd[r_head]  != '0)};
  assign commit_rd    = {r_rd[w_head1], r_rd[r_head]};
  assign commit_tag   = {w_head1, r_head};
  assign commit_value = {r_value[w_head1], r_value[r_head]};
  assign flush        = w_flush;
  assign flush_pc     = r_npc[r_head];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head   <= tag_t'(1);
      r_tail   <= tag_t'(1);
      r_count  <= '0;
      r_ready  <= '0;
      r_store  <= '0;
      r_branch <= '0;
    end else if (rdy_in) begin
      if (w_flush) begin
        r_head   <= tag_t'(1);
        r_tail   <= tag_t'(1);
        r_count  <= '0;
        r_ready  <= '0;
        r_store  <= '0;
        r_branch <= '0;
      end else begin
        if (slb_valid && slb_tag != '0) r_ready[slb_tag] <= 1'b1;
        if (ex_valid && ex_tag != '0)   r_ready[ex_tag]  <= 1'b1;
        if (w_issue) begin
          r_ready[r_tail]  <= issue_is_store;
          r_store[r_tail]  <= issue_is_store;
          r_branch[r_tail] <= issue_is_branch;
          r_tail           <= w_tail1;
        end
        r_head  <= w_head_nxt;
        r_count <= r_count + tag_t'(w_issue) - w_ncommit;
      end
    end
  end

  // Payload arrays carry no reset; their validity is tracked by the flag bits.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !w_flush) begin
      if (slb_valid && slb_tag != '0) r_value[slb_tag] <= slb_value;
      if (ex_valid && ex_tag != '0) begin
        r_value[ex_tag] <= ex_value;
        r_npc[ex_tag]   <= ex_npc;
      end
      if (w_issue) begin
        r_rd[r_tail]      <= issue_rd;
        r_pred_pc[r_tail] <= issue_pred_pc;
      end
    end
  end

  tag_t [1:0]        w_lk_tag;
  logic [1:0]        w_lk_ready;
  logic [1:0][31:0]  w_lk_value;

  assign w_lk_tag = {rd_tag2, rd_tag1};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    rob_fwd #(.Q_WIDTH(Q_WIDTH)) u_fwd (
      .i_tag       (w_lk_tag[g]),
      .i_ex_valid  (ex_valid),
      .i_ex_tag    (ex_tag),
      .i_ex_value  (ex_value),
      .i_slb_valid (slb_valid),
      .i_slb_tag   (slb_tag),
      .i_slb_value (slb_value),
      .i_ent_ready (r_ready[w_lk_tag[g]]),
      .i_ent_value (r_value[w_lk_tag[g]]),
      .o_ready     (w_lk_ready[g]),
      .o_value     (w_lk_value[g])
    );
  end

  assign rd_ready1 = w_lk_ready[0];
  assign rd_ready2 = w_lk_ready[1];
  assign rd_value1 = w_lk_value[0];
  assign rd_value2 = w_lk_value[1];

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 5, architectural register index width.
REQ-002 SHALL have parameter Q_WIDTH, default 4: tag width; 2**Q_WIDTH slots, tag 0 reserved as "no tag", capacity 2**Q_WIDTH-1.
REQ-003 SHALL have one clock and an asynchronous, active-low reset:
- clk_in  in  1  clock, rising edge
- rst_in  in  1  asynchronous reset, active-low
- rdy_in  in  1  global enable; low freezes all state
- issue_valid  in  1  dispatch request
- issue_is_store  in  1  entry is a store (born ready)
- issue_is_branch  in  1  entry is a branch/jump
- issue_rd  in  REG_ADDR_WIDTH  destination register
- issue_pred_pc  in  32  predicted next pc
- issue_tag  out  Q_WIDTH  tag the next accepted issue receives (tail)
- full  out  1  no free slot
- empty  out  1  no occupied slot
- ex_valid, ex_tag, ex_value, ex_npc  in  1/Q_WIDTH/32/32  ALU/branch writeback
- slb_valid, slb_tag, slb_value  in  1/Q_WIDTH/32  load writeback
- rd_tag1, rd_tag2  in  Q_WIDTH  operand lookup tags
- rd_ready1, rd_ready2  out  1  lookup value available
- rd_value1, rd_value2  out  32  lookup value
- commit_valid  out  2  per-slot commit strobe, bit0 = oldest
- commit_wen  out  2  per-slot register-file write enable
- commit_rd  out  2*REG_ADDR_WIDTH  per-slot destination
- commit_tag  out  2*Q_WIDTH  per-slot tag
- commit_value  out  64  per-slot value
- flush  out  1  misprediction flush
- flush_pc  out  32  redirect target

Function
REQ-004 Tags SHALL advance 1..2**Q_WIDTH-1 and wrap to 1, never 0; head/tail use same increment.
REQ-005 Issue SHALL be accepted iff issue_valid && !full && !flush && rdy_in; slot written with rd, pred_pc, store/branch flags, ready=issue_is_store; tail advances.
REQ-006 full SHALL equal count==2**Q_WIDTH-1 from registered count; issue at full is refused even if a commit occurs same cycle.
REQ-007 Writeback SHALL set value and ready (ex also sets npc) on the clock edge; tag 0 ignored; same tag on both ports: ex wins.
REQ-008 Slot 0 SHALL commit when !empty and head ready; slot 1 SHALL commit when slot 0 commits, count>=2, head+1 ready, and neither entry is a branch.
REQ-009 Commit outputs SHALL be combinational from registered state; head and count update on the same edge (count_next = count + issued - committed).
REQ-010 commit_wen[i] SHALL be 0 for stores, branches, or rd==0.
REQ-011 Head branch ready with npc != pred_pc SHALL assert commit_valid=2'b01, flush=1, flush_pc=npc; next edge head=tail=1, count=0, all ready/store/branch bits cleared, same-cycle issue and writebacks discarded.
REQ-012 rd_readyN SHALL be entry ready OR same-cycle writeback hit; rd_valueN forwards ex over slb over stored value; tag 0 returns ready=0, value=0.
REQ-013 rdy_in low SHALL hold all state and force commit_valid=0, flush=0.

Reset
REQ-014 Asserting rst_in SHALL immediately set head=tail=1, count=0, all ready/store/branch bits 0; value/pc arrays unreset.
REQ-015 Reset output values: issue_tag=1, empty=1, full=0, commit_valid=0, commit_wen=0, flush=0, rd_ready*=0.

Structure
REQ-016 Shared header rob_defs SHALL hold REG_ADDR_WIDTH/Q_WIDTH defaults and the zero-skipping tag-increment function.
REQ-017 One sub-module rob_fwd (tag lookup with writeback forwarding) SHALL be instantiated per lookup port.

Verification
REQ-018 Reset, issue 16 with Q_WIDTH=4 -> tags 1..15, full=1 after 15th, 16th refused, issue_tag=1.
REQ-019 Issue tag1 rd=3, tag2 rd=4; ex writes tag2=0x22 then tag1=0x11 -> no commit until tag1 ready, then commit_valid=2'b11, values 0x11/0x22, wen=2'b11.
REQ-020 Branch tag1 pred 0x100, ex npc 0x104 -> commit_valid=2'b01, wen=0, flush=1, flush_pc=0x104; next cycle empty=1, issue_tag=1.
REQ-021 Tag3 pending, ex_valid tag3 value 0xDEAD, rd_tag1=3 same cycle -> rd_ready1=1, rd_value1=0xDEAD.
REQ-022 Head at 15, tags 15 and 1 ready -> dual commit, head becomes 2; rdy_in low with ready head -> no commit.
REQ-023 rst_in low mid-operation without clock edge -> all outputs at REQ-015 values immediately.
